// File: rtl/fpga_cfg_seq_if.sv
// FPGA passive-configuration handshake and board reset signals for fpga_cfg_seq.
// slave = sequencer side, master = FPGA/host side.
interface fpga_cfg_seq_if;
    logic       start;
    logic       status_n;
    logic       conf_done;
    logic       init_done;
    logic       config_n;
    logic       cs;
    logic       warmres_n;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] retry;

    modport slave (
        input  start, status_n, conf_done, init_done,
        output config_n, cs, warmres_n, busy, done, fail, retry
    );

    modport master (
        output start, status_n, conf_done, init_done,
        input  config_n, cs, warmres_n, busy, done, fail, retry
    );
endinterface

// File: rtl/fpga_cfg_seq.sv
// ACEX1K passive configuration sequencer with bounded retries and warm-reset hold.
// Define FPGA_CFG_INIT_DONE_EN to wait for INIT_DONE before releasing warm reset.
//
// state | meaning
// NCFG  | config_n held low for NCFG_LEN cycles
// WSTAT | config_n released, waiting for nSTATUS high
// WCONF | waiting for CONF_DONE high, nSTATUS low is an error
// WINIT | waiting for INIT_DONE high (FPGA_CFG_INIT_DONE_EN builds only)
// WRES  | FPGA in user mode, warm reset held for WRES_LEN cycles
// DONE  | configured, warm reset released, watching CONF_DONE
// ERR   | one-cycle retry decision
// FAIL  | retries exhausted, FPGA held in reset
module fpga_cfg_seq #(
    parameter int NCFG_LEN  = 48,
    parameter int STAT_TO   = 1024,
    parameter int CONF_TO   = 1000000,
    parameter int INIT_TO   = 4096,
    parameter int WRES_LEN  = 256,
    parameter int MAX_RETRY = 3
) (
    input  logic            clkin,
    input  logic            coldres_n,
    fpga_cfg_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_NCFG  = 3'd0,
        S_WSTAT = 3'd1,
        S_WCONF = 3'd2,
        S_WRES  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_FAIL  = 3'd6
`ifdef FPGA_CFG_INIT_DONE_EN
        , S_WINIT = 3'd7
`endif
    } state_t;

    if (NCFG_LEN < 2 || STAT_TO < 1 || CONF_TO < 1 || INIT_TO < 1 || WRES_LEN < 1 ||
        MAX_RETRY < 0 || MAX_RETRY > 3 || NCFG_LEN > 1048576 || STAT_TO > 1048576 ||
        CONF_TO > 1048576 || INIT_TO > 1048576 || WRES_LEN > 1048576) begin : g_bad_params
        $error("fpga_cfg_seq: parameter out of range");
    end

    localparam logic [19:0] NCFG_TC  = 20'(NCFG_LEN - 1);
    localparam logic [19:0] STAT_TC  = 20'(STAT_TO - 1);
    localparam logic [19:0] CONF_TC  = 20'(CONF_TO - 1);
    localparam logic [19:0] WRES_TC  = 20'(WRES_LEN - 1);
    localparam logic [1:0]  RETRY_MX = 2'(MAX_RETRY);
`ifdef FPGA_CFG_INIT_DONE_EN
    localparam logic [19:0] INIT_TC  = 20'(INIT_TO - 1);
`endif

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic        run_q, run_d;
    logic        sts_meta_q, sts_meta_d, sts_q, sts_d;
    logic        cdn_meta_q, cdn_meta_d, cdn_q, cdn_d;
    logic        ini_meta_q, ini_meta_d, ini_q, ini_d;
    logic        config_n_q, config_n_d;
    logic        cs_q, cs_d;
    logic        warmres_n_q, warmres_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;

    always_comb begin
        sts_meta_d = bus.status_n;
        sts_d      = sts_meta_q;
        cdn_meta_d = bus.conf_done;
        cdn_d      = cdn_meta_q;
        ini_meta_d = bus.init_done;
        ini_d      = ini_meta_q;
        run_d      = 1'b1;
        state_d    = state_q;
        retry_d    = retry_q;

        case (state_q)
            // run_q treats the first edge after reset release as the NCFG entry edge
            S_NCFG:  if (run_q && cnt_q == NCFG_TC) state_d = S_WSTAT;
            S_WSTAT: begin
                if (sts_q)                 state_d = S_WCONF;
                else if (cnt_q == STAT_TC) state_d = S_ERR;
            end
            S_WCONF: begin
                if (!sts_q)                state_d = S_ERR;
`ifdef FPGA_CFG_INIT_DONE_EN
                else if (cdn_q)            state_d = S_WINIT;
`else
                else if (cdn_q)            state_d = S_WRES;
`endif
                else if (cnt_q == CONF_TC) state_d = S_ERR;
            end
`ifdef FPGA_CFG_INIT_DONE_EN
            S_WINIT: begin
                if (!sts_q)                state_d = S_ERR;
                else if (ini_q)            state_d = S_WRES;
                else if (cnt_q == INIT_TC) state_d = S_ERR;
            end
`endif
            S_WRES:  if (cnt_q == WRES_TC) state_d = S_DONE;
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_NCFG;
                    retry_d = 2'd0;
                end else if (!cdn_q) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (retry_q < RETRY_MX) begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_NCFG;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (bus.start) begin
                    state_d = S_NCFG;
                    retry_d = 2'd0;
                end
            end
            default: state_d = S_NCFG;
        endcase

        if (state_d != state_q)
            cnt_d = 20'd0;
        else if (!run_q || state_q == S_DONE || state_q == S_FAIL)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 20'd1;

        config_n_d  = !(state_d == S_NCFG || state_d == S_FAIL);
        cs_d        = (state_d == S_FAIL);
        warmres_n_d = (state_d == S_DONE);
        done_d      = (state_d == S_DONE);
        fail_d      = (state_d == S_FAIL);
        busy_d      = !(state_d == S_DONE || state_d == S_FAIL);
    end

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            state_q     <= S_NCFG;
            cnt_q       <= 20'd0;
            retry_q     <= 2'd0;
            run_q       <= 1'b0;
            sts_meta_q  <= 1'b0;
            sts_q       <= 1'b0;
            cdn_meta_q  <= 1'b0;
            cdn_q       <= 1'b0;
            ini_meta_q  <= 1'b0;
            ini_q       <= 1'b0;
            config_n_q  <= 1'b0;
            cs_q        <= 1'b0;
            warmres_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            run_q       <= run_d;
            sts_meta_q  <= sts_meta_d;
            sts_q       <= sts_d;
            cdn_meta_q  <= cdn_meta_d;
            cdn_q       <= cdn_d;
            ini_meta_q  <= ini_meta_d;
            ini_q       <= ini_d;
            config_n_q  <= config_n_d;
            cs_q        <= cs_d;
            warmres_n_q <= warmres_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.config_n  = config_n_q;
    assign bus.cs        = cs_q;
    assign bus.warmres_n = warmres_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.retry     = retry_q;

endmodule
